// File: rtl/spell_pkg.sv
// spell_pkg: shared FSM encoding and bus field widths for the spell RAM block
package spell_pkg;
  localparam int ADDR_W = 8;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;
endpackage

// File: rtl/spell_ram_array.sv
// spell_ram_array: DEPTH x 32 storage, byte-enabled synchronous write, registered read
module spell_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i)
      for (int i = 0; i < 4; i++)
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/spell_rambus_ram.sv
// spell_rambus_ram: Wishbone-style single-port RAM with programmable wait states
module spell_rambus_ram
  import spell_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q, ack_q, zero_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       dat_q, rdata;
  logic              req, idle, go, a_we, in_rng;
  logic [3:0]        a_sel;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_dat;
  // With zero wait states the access happens on the detect edge, so live inputs are used
  assign req    = wb_cyc_i & wb_stb_i;
  assign idle   = state_q == S_IDLE;
  assign a_we   = idle ? wb_we_i : we_q;
  assign a_sel  = idle ? wb_sel_i : sel_q;
  assign a_addr = idle ? wb_addr_i : addr_q;
  assign a_dat  = idle ? wb_dat_i : dat_q;
  assign in_rng = {1'b0, a_addr} < LIM;
  assign go     = !reset && req && (idle ? WAIT_STATES == 0 : state_q == S_WAIT && cnt_q == '0);
  spell_ram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clock),
    .we_i    (go && a_we && in_rng),
    .re_i    (go && !a_we && in_rng),
    .be_i    (a_sel),
    .addr_i  (a_addr[AW-1:0]),
    .wdata_i (a_dat),
    .rdata_o (rdata)
  );
  // zero_q masks the array output after reset and for out-of-range reads
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      ack_q <= go;
      if (go && !a_we) zero_q <= !in_rng;
      case (state_q)
        S_IDLE: if (req) begin
          we_q    <= wb_we_i;
          sel_q   <= wb_sel_i;
          addr_q  <= wb_addr_i;
          dat_q   <= wb_dat_i;
          state_q <= WAIT_STATES == 0 ? S_ACK : S_WAIT;
          cnt_q   <= WAIT_STATES == 0 ? '0 : CNT_W'(WAIT_STATES - 1);
        end
        S_WAIT: if (!req) state_q <= S_IDLE;
          else if (cnt_q == '0) state_q <= S_ACK;
          else cnt_q <= cnt_q - CNT_W'(1);
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign wb_ack_o = ack_q;
  assign wb_dat_o = zero_q ? '0 : rdata;
endmodule
